uart_prog_loader: RTL

//  Receives a program image over a UART RX line and writes it word by word into program memory (pm_rom write side).

---
 rtl/loader_pkg.sv | 26 ++
 rtl/uart_rx_core.sv | 151 +++++++++++++++
 rtl/uart_prog_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants, state encodings and helpers for the UART program loader.
// LOADER_PARITY_EN adds an even-parity state to the receiver encoding.
package loader_pkg;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 9600;
  localparam int DEF_OVS       = 16;
  localparam int BAUD_DIV      = DEF_CLK_FREQ / (DEF_BAUD_RATE * DEF_OVS);
  localparam int MID_TICK      = DEF_OVS / 2;
  localparam int BIT_TICKS     = DEF_OVS;

`ifdef LOADER_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`endif

  typedef enum logic [2:0] {
    L_CNT_HI, L_CNT_LO, L_WORD_HI, L_WORD_LO, L_DONE, L_ERR
  } ld_state_e;

  function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-FF synchroniser, baud tick, 8N1 (or 8E1 with
// LOADER_PARITY_EN) framing; emits one-cycle rx_valid / rx_ferr / rx_perr pulses.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int OVS       = DEF_OVS
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_ferr,
  output logic       o_rx_perr
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] MID_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVS - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [DW-1:0] div_q;
  logic          tick_q;
  rx_state_e     state_q;
  logic [TW-1:0] tcnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic [7:0]    byte_q;
  logic          ferr_q;
`ifdef LOADER_PARITY_EN
  logic          par_bad_q;
  logic          perr_q;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= 2'b11;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      tick_q <= (div_q == DIV_LAST);
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= RX_IDLE;
      tcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      byte_q    <= '0;
      ferr_q    <= 1'b0;
`ifdef LOADER_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef LOADER_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_q <= RX_START;
            tcnt_q  <= '0;
          end
        end
        RX_START: if (tick_q) begin
          // A start bit that is high again at mid-bit was only a glitch
          if (tcnt_q == MID_LAST) begin
            tcnt_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RX_DATA: if (tick_q) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_q  <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
`ifdef LOADER_PARITY_EN
        RX_PARITY: if (tick_q) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_q    <= '0;
            par_bad_q <= (rx_s != ^shift_q);
            state_q   <= RX_STOP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: if (tick_q) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_q  <= '0;
            state_q <= RX_IDLE;
            if (!rx_s) begin
              ferr_q <= 1'b1;
`ifdef LOADER_PARITY_EN
            end else if (par_bad_q) begin
              perr_q <= 1'b1;
`endif
            end else begin
              valid_q <= 1'b1;
              byte_q  <= shift_q;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_valid = valid_q;
  assign o_rx_byte  = byte_q;
  assign o_rx_ferr  = ferr_q;
`ifdef LOADER_PARITY_EN
  assign o_rx_perr  = perr_q;
`else
  assign o_rx_perr  = 1'b0;
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed program image from UART into program memory and holds
// the processor in reset until it is complete. LOADER_PARITY_EN selects 8E1 framing.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int DATA_LENGTH = 16,
  parameter int ADDR_LENGTH = 11,
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
  parameter int OVS         = DEF_OVS
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_rx,
  output logic                   o_wr_en,
  output logic [ADDR_LENGTH-1:0] o_wr_addr,
  output logic [DATA_LENGTH-1:0] o_wr_data,
  output logic                   o_proc_rst,
  output logic                   o_load_done,
  output logic                   o_load_err
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_LENGTH);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic       rx_perr;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .OVS      (OVS)
  ) u_rx (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_rx      (i_rx),
    .o_rx_valid(rx_valid),
    .o_rx_byte (rx_byte),
    .o_rx_ferr (rx_ferr),
    .o_rx_perr (rx_perr)
  );

  ld_state_e              state_q;
  logic [15:0]            cnt_q;
  logic [ADDR_LENGTH:0]   addr_q;
  logic [7:0]             word_hi_q;
  logic                   wr_en_q;
  logic [ADDR_LENGTH-1:0] wr_addr_q;
  logic [DATA_LENGTH-1:0] wr_data_q;
  logic                   proc_rst_q;
  logic                   done_q;
  logic                   err_q;
  logic [15:0]            n_word;
  logic                   last_word;

  assign n_word    = {cnt_q[15:8], rx_byte};
  assign last_word = (16'(addr_q) == cnt_q - 16'd1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= L_CNT_HI;
      cnt_q      <= '0;
      addr_q     <= '0;
      word_hi_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      proc_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      // Once the image is complete the line is no longer our concern
      if ((rx_ferr || rx_perr) && state_q != L_DONE) begin
        state_q <= L_ERR;
        err_q   <= 1'b1;
      end else if (rx_valid) begin
        case (state_q)
          L_CNT_HI: begin
            cnt_q   <= {rx_byte, 8'h00};
            state_q <= L_CNT_LO;
          end
          L_CNT_LO: begin
            cnt_q <= n_word;
            if (n_word == 16'd0) begin
              state_q    <= L_DONE;
              done_q     <= 1'b1;
              proc_rst_q <= 1'b0;
            end else if ({1'b0, n_word} > MAX_WORDS) begin
              state_q <= L_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= L_WORD_HI;
            end
          end
          L_WORD_HI: begin
            word_hi_q <= rx_byte;
            state_q   <= L_WORD_LO;
          end
          L_WORD_LO: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q[ADDR_LENGTH-1:0];
            wr_data_q <= DATA_LENGTH'({word_hi_q, rx_byte});
            addr_q    <= addr_q + 1'b1;
            if (last_word) begin
              state_q    <= L_DONE;
              done_q     <= 1'b1;
              proc_rst_q <= 1'b0;
            end else begin
              state_q <= L_WORD_HI;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_proc_rst  = proc_rst_q;
  assign o_load_done = done_q;
  assign o_load_err  = err_q;

endmodule
